frame_dispatch: RTL and testbench

//  Switch-core egress dispatcher; receiving end of the sof/dv/data stream from the frame processor.
//  - Decodes the 2-byte header and counts body bytes.
//  - Fans each body byte out to the per-port output data FIFOs selected by the header portmap.
//  - After the last byte, commits one pointer word per selected port.
//  - Drives the bp0..bp3 backpressure lines back to the frame processor.

---
 rtl/sw_pkg.sv | 26 ++
 rtl/frame_dispatch_if.sv | 26 ++
 rtl/frame_dispatch.sv | 124 ++++++++++++
 tb/tb_frame_dispatch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared switch-core definitions: header/pointer field layout and dispatcher FSM states.
package sw_pkg;

  localparam int NPORT      = 4;
  localparam int PM_LSB     = 0;
  localparam int PM_W       = 4;
  localparam int LEN_HI_LSB = 4;
  localparam int PTR_BAD    = 15;
  localparam int PTR_LEN_W  = 11;
  localparam int PTR_W      = PTR_BAD + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR1   = 3'd1,
    ST_BODY   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DROP   = 3'd4
  } state_t;

  // Pointer word: bad flag on top, body byte count in the low bits.
  function automatic logic [PTR_W-1:0] make_ptr(input logic bad,
                                                input logic [PTR_LEN_W-1:0] cnt);
    make_ptr = {bad, {(PTR_W-1-PTR_LEN_W){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/frame_dispatch_if.sv
// Ingress byte stream plus per-port egress FIFO write side of the frame dispatcher.
interface frame_dispatch_if;

  logic                     sof;
  logic                     dv;
  logic [7:0]               data;
  logic [sw_pkg::NPORT-1:0] ofifo_afull;
  logic [sw_pkg::NPORT-1:0] optr_full;
  logic [sw_pkg::NPORT-1:0] ofifo_wr;
  logic [7:0]               ofifo_din;
  logic [sw_pkg::NPORT-1:0] optr_wr;
  logic [sw_pkg::PTR_W-1:0] optr_din;

  // Dispatcher side.
  modport slave (
    input  sof, dv, data, ofifo_afull, optr_full,
    output ofifo_wr, ofifo_din, optr_wr, optr_din
  );

  // Frame processor / FIFO side.
  modport master (
    output sof, dv, data, ofifo_afull, optr_full,
    input  ofifo_wr, ofifo_din, optr_wr, optr_din
  );

endinterface

// File: rtl/frame_dispatch.sv
// Egress dispatcher: decodes the 2-byte header, fans body bytes out to the selected
// port FIFOs, then commits one pointer word per port; empty-mask frames are dropped.
module frame_dispatch
  import sw_pkg::*;
#(
  parameter int MAX_LEN = 1536,
  parameter int MIN_LEN = 14
) (
  input  logic             clk,
  input  logic             rstn,
  frame_dispatch_if.slave  bus,
  output logic             bp0,
  output logic             bp1,
  output logic             bp2,
  output logic             bp3,
  output logic [15:0]      drop_cnt
);

  localparam logic [PTR_LEN_W-1:0] MIN_C = PTR_LEN_W'(MIN_LEN);
  localparam logic [PTR_LEN_W-1:0] MAX_C = PTR_LEN_W'(MAX_LEN);

  state_t                 state, state_nx;
  logic [NPORT-1:0]       mask;
  logic [NPORT-1:0]       mask_eff;
  logic [PTR_LEN_W-1:0]   cnt;
  logic                   trunc;
  logic                   bad;
  logic [NPORT-1:0]       bp;
  logic                   sof_v;

  logic load_mask, clr_cnt, wr_byte, do_commit, count_drop, set_trunc;

  assign sof_v    = bus.sof & bus.dv;
  assign mask_eff = bus.data[PM_LSB +: PM_W] & ~bus.ofifo_afull & ~bus.optr_full;
  assign bad      = trunc | (cnt < MIN_C) | (cnt > MAX_C);

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_nx   = state;
    load_mask  = 1'b0;
    clr_cnt    = 1'b0;
    wr_byte    = 1'b0;
    do_commit  = 1'b0;
    count_drop = 1'b0;
    set_trunc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sof_v) begin
          load_mask = 1'b1;
          state_nx  = (mask_eff != '0) ? ST_HDR1 : ST_DROP;
        end
      end
      ST_HDR1: begin
        if (bus.dv) begin
          clr_cnt  = 1'b1;
          state_nx = ST_BODY;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BODY: begin
        // A new sof cuts the current frame short; its header byte is not written.
        if (sof_v) begin
          set_trunc = 1'b1;
          state_nx  = ST_COMMIT;
        end else if (bus.dv) begin
          wr_byte = 1'b1;
        end else begin
          state_nx = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        do_commit = 1'b1;
        state_nx  = (trunc || sof_v) ? ST_DROP : ST_IDLE;
      end
      ST_DROP: begin
        if (!bus.dv) begin
          count_drop = 1'b1;
          state_nx   = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the data buses are reset too, since every output must read 0 out of reset.
      bus.ofifo_wr  <= '0;
      bus.ofifo_din <= '0;
      bus.optr_wr   <= '0;
      bus.optr_din  <= '0;
      mask          <= '0;
      cnt           <= '0;
      trunc         <= 1'b0;
      drop_cnt      <= '0;
      bp            <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus.ofifo_wr <= wr_byte ? mask : '0;
      if (wr_byte) bus.ofifo_din <= bus.data;
      bus.optr_wr <= do_commit ? mask : '0;
      if (do_commit) bus.optr_din <= make_ptr(bad, cnt);
      if (load_mask) mask <= mask_eff;
      if (clr_cnt)                     cnt <= '0;
      else if (wr_byte && cnt != '1)   cnt <= cnt + 1'b1;
      if (clr_cnt)        trunc <= 1'b0;
      else if (set_trunc) trunc <= 1'b1;
      if (count_drop) drop_cnt <= drop_cnt + 16'd1;
      bp <= bus.ofifo_afull | bus.optr_full;
    end
  end

  assign bp0 = bp[0];
  assign bp1 = bp[1];
  assign bp2 = bp[2];
  assign bp3 = bp[3];

endmodule

// File: tb/tb_frame_dispatch.sv
// Directed bench for frame_dispatch: unicast, masked broadcast, drop, runt, truncation,
// length boundaries and mid-frame reset, with hand-computed expected pointer words.
module tb_frame_dispatch;
  import sw_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bp0, bp1, bp2, bp3;
  logic [15:0] drop_cnt;

  frame_dispatch_if bus();

  frame_dispatch #(.MAX_LEN(1536), .MIN_LEN(14)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .bp0      (bp0),
    .bp1      (bp1),
    .bp2      (bp2),
    .bp3      (bp3),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Cumulative egress monitor, sampled on the falling edge.
  int          wr_n [4] = '{0, 0, 0, 0};
  int          wr_total = 0;
  int          wr_sum = 0;
  int          wr_at_ptr = 0;
  int          ptr_n = 0;
  int          overlap = 0;
  logic [3:0]  ptr_mask_last = '0;
  logic [15:0] ptr_din_last = '0;

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++)
      if (bus.ofifo_wr[p]) wr_n[p] <= wr_n[p] + 1;
    if (bus.ofifo_wr != '0) begin
      wr_total <= wr_total + 1;
      wr_sum   <= wr_sum + int'(bus.ofifo_din);
    end
    if (bus.optr_wr != '0) begin
      ptr_n         <= ptr_n + 1;
      ptr_mask_last <= bus.optr_wr;
      ptr_din_last  <= bus.optr_din;
      wr_at_ptr     <= wr_total + ((bus.ofifo_wr != '0) ? 1 : 0);
      if (bus.ofifo_wr != '0) overlap <= overlap + 1;
    end
  end

  int s_wr [4];
  int s_tot, s_ptr, s_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic snap();
    for (int p = 0; p < 4; p++) s_wr[p] = wr_n[p];
    s_tot = wr_total;
    s_ptr = ptr_n;
    s_sum = wr_sum;
  endtask

  task automatic send_frame(input logic [7:0] hdr0, input int len,
                            input logic [7:0] seed, input bit keep_dv);
    bus.sof  = 1'b1;
    bus.dv   = 1'b1;
    bus.data = hdr0;
    step();
    bus.sof  = 1'b0;
    bus.data = len[7:0];
    step();
    for (int i = 0; i < len; i++) begin
      bus.data = seed + 8'(i);
      step();
    end
    if (!keep_dv) begin
      bus.dv   = 1'b0;
      bus.data = '0;
    end
  endtask

  // One committed frame: port write counts, single pointer pulse, pointer word, ordering.
  task automatic expect_frame(input string tag, input logic [3:0] m, input int len,
                              input logic [15:0] din);
    for (int p = 0; p < 4; p++)
      check($sformatf("%s_wr%0d", tag, p), 32'(wr_n[p] - s_wr[p]), m[p] ? 32'(len) : 32'd0);
    check({tag, "_ptr_n"},    32'(ptr_n - s_ptr), 32'd1);
    check({tag, "_ptr_mask"}, 32'(ptr_mask_last), 32'(m));
    check({tag, "_ptr_din"},  32'(ptr_din_last),  32'(din));
    check({tag, "_order"},    32'(wr_at_ptr - s_tot), 32'(len));
  endtask

  initial begin
    bus.sof = 1'b0; bus.dv = 1'b0; bus.data = '0;
    bus.ofifo_afull = '0; bus.optr_full = '0;

    // Reset state
    idle(2);
    check("rst_outs", {bus.ofifo_wr, bus.optr_wr, bus.ofifo_din, bus.optr_din},
          32'h0000_0000);
    check("rst_bp_drop", {12'd0, bp3, bp2, bp1, bp0, drop_cnt}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // 1. Unicast to port 1, 64-byte body, data sum 64*0x10 + 0+..+63 = 3040
    snap();
    send_frame(8'h42, 64, 8'h10, 1'b0);
    idle(6);
    expect_frame("uni", 4'b0010, 64, 16'h0040);
    check("uni_sum", 32'(wr_sum - s_sum), 32'd3040);
    check("uni_drop", 32'(drop_cnt), 32'd0);

    // 2. Broadcast 1110 with port 2 almost full -> effective 1010
    bus.ofifo_afull = 4'b0100;
    check("bp2_before", 32'(bp2), 32'd0);
    step();
    check("bp2_after", {28'd0, bp3, bp2, bp1, bp0}, 32'b0100);
    snap();
    send_frame(8'h0E, 32, 8'hA0, 1'b0);
    idle(6);
    expect_frame("bc", 4'b1010, 32, 16'h0020);
    bus.ofifo_afull = '0;

    // 3. Only port 0 requested, its pointer FIFO full -> dropped
    bus.optr_full = 4'b0001;
    step();
    check("bp0_full", {28'd0, bp3, bp2, bp1, bp0}, 32'b0001);
    snap();
    send_frame(8'h01, 16, 8'h00, 1'b0);
    idle(6);
    check("drop_wr",  32'(wr_total - s_tot), 32'd0);
    check("drop_ptr", 32'(ptr_n - s_ptr), 32'd0);
    check("drop_cnt1", 32'(drop_cnt), 32'd1);
    bus.optr_full = '0;
    idle(2);

    // 4. Runt: 10 bytes to port 3
    snap();
    send_frame(8'h08, 10, 8'h33, 1'b0);
    idle(6);
    expect_frame("runt", 4'b1000, 10, 16'h800A);

    // 5. Truncation: sof after 20 bytes of frame 1; frame 2 is dropped
    snap();
    send_frame(8'h01, 20, 8'h55, 1'b1);
    send_frame(8'h04, 30, 8'h66, 1'b0);
    idle(6);
    expect_frame("trunc", 4'b0001, 20, 16'h8014);
    check("trunc_drop", 32'(drop_cnt), 32'd2);

    // Length boundaries: 14 ok, 13 runt, 1536 ok, 1537 oversize
    snap(); send_frame(8'h01, 14, 8'h01, 1'b0); idle(6);
    expect_frame("len14", 4'b0001, 14, 16'h000E);
    snap(); send_frame(8'h01, 13, 8'h02, 1'b0); idle(6);
    expect_frame("len13", 4'b0001, 13, 16'h800D);
    snap(); send_frame(8'h62, 1536, 8'h03, 1'b0); idle(6);
    expect_frame("len1536", 4'b0010, 1536, 16'h0600);
    snap(); send_frame(8'h62, 1537, 8'h04, 1'b0); idle(6);
    expect_frame("len1537", 4'b0010, 1537, 16'h8601);

    // 6. Reset for one cycle mid-BODY after 5 bytes to port 1
    snap();
    bus.sof = 1'b1; bus.dv = 1'b1; bus.data = 8'h02; step();
    bus.sof = 1'b0; bus.data = 8'h28; step();
    for (int i = 0; i < 5; i++) begin
      bus.data = 8'hC0 + 8'(i);
      step();
    end
    bus.dv = 1'b0; bus.data = '0;
    bus.optr_full = 4'b1000;
    rstn = 1'b0;
    step();
    check("mrst_outs", {bus.ofifo_wr, bus.optr_wr, bus.ofifo_din, bus.optr_din},
          32'h0000_0000);
    check("mrst_bp_drop", {12'd0, bp3, bp2, bp1, bp0, drop_cnt}, 32'd0);
    rstn = 1'b1;
    bus.optr_full = '0;
    idle(6);
    check("mrst_ptr", 32'(ptr_n - s_ptr), 32'd0);
    check("mrst_kept", 32'(wr_n[1] - s_wr[1]), 32'd5);
    snap();
    send_frame(8'h04, 20, 8'h77, 1'b0);
    idle(6);
    expect_frame("post_rst", 4'b0100, 20, 16'h0014);
    check("post_rst_drop", 32'(drop_cnt), 32'd0);
    check("no_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
